regfile_dump: RTL and testbench



---
 rtl/regfile_dbg_pkg.sv | 15 +
 rtl/regfile_dump.sv | 107 ++++++++++
 tb/tb_regfile_dump.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dbg_pkg.sv
// Shared types and default geometry for the regfile debug readout engine.
package regfile_dbg_pkg;

  localparam int unsigned NregsDef = 32;
  localparam int unsigned AwDef    = 5;
  localparam int unsigned DwDef    = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StSend,
    StDone
  } state_e;

endpackage

// File: rtl/regfile_dump.sv
// Walks a register range through one regfile read port and streams each value
// out over a valid/ready handshake; abort drops the stream without a done pulse.
module regfile_dump
  import regfile_dbg_pkg::*;
#(
  parameter int unsigned NREGS = NregsDef,
  parameter int unsigned AW    = AwDef,
  parameter int unsigned DW    = DwDef
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] first,
  input  logic [AW-1:0] last,
  input  logic          abort,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_index,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] last_q, last_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] index_q, index_d;
  logic          olast_q, olast_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      last_q  <= '0;
      data_q  <= '0;
      index_q <= '0;
      olast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      data_q  <= data_d;
      index_q <= index_d;
      olast_q <= olast_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    data_d  = data_q;
    index_d = index_q;
    olast_d = olast_q;

    unique case (state_q)
      StIdle: begin
        // A start coinciding with abort is treated as cancelled.
        if (start && !abort) begin
          ptr_d   = first;
          last_d  = last;
          state_d = StRead;
        end
      end
      StRead: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          data_d  = rd_data;
          index_d = ptr_q;
          olast_d = (ptr_q == last_q);
          state_d = StSend;
        end
      end
      StSend: begin
        if (abort) begin
          state_d = StIdle;
        end else if (out_ready) begin
          if (olast_q) begin
            state_d = StDone;
          end else begin
            ptr_d   = (ptr_q == AW'(NREGS - 1)) ? '0 : ptr_q + 1'b1;
            state_d = StRead;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rd_addr   = ptr_q;
  assign out_valid = (state_q == StSend);
  assign out_data  = data_q;
  assign out_index = index_q;
  assign out_last  = olast_q;
  assign busy      = (state_q != StIdle);
  // An abort landing on the done cycle suppresses the pulse.
  assign done      = (state_q == StDone) && !abort;

endmodule

// File: tb/tb_regfile_dump.sv
// Randomized self-checking bench for regfile_dump against a word-list model of each dump.
module tb_regfile_dump;

  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  logic          clk       = 1'b0;
  logic          reset_n   = 1'b0;
  logic          start     = 1'b0;
  logic          abort     = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] first     = '0;
  logic [AW-1:0] last      = '0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] rf [NREGS];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rd_data = rf[rd_addr];

  regfile_dump #(
    .NREGS(NREGS),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .first    (first),
    .last     (last),
    .abort    (abort),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"},  out_data,  0);
    check({tag, "_index"}, out_index, 0);
    check({tag, "_last"},  out_last,  0);
    check({tag, "_busy"},  busy,      0);
    check({tag, "_done"},  done,      0);
    check({tag, "_raddr"}, rd_addr,   0);
  endtask

  // Called at posedge+1. The model is the ordered word list the range implies.
  task automatic dump(input int f, input int l, input bit rnd, input int abort_idx,
                      input int rst_idx, input bit noise);
    int            n;
    int            k;
    bit            fin;
    bit            stalled;
    logic [DW-1:0] pd;
    logic [AW-1:0] pi;
    logic          pl;
    int            exp_i [$];
    logic [DW-1:0] exp_d [$];
    n       = ((l - f) % int'(NREGS) + int'(NREGS)) % int'(NREGS) + 1;
    k       = 0;
    fin     = 0;
    stalled = 0;
    pd      = '0;
    pi      = '0;
    pl      = 1'b0;
    for (int j = 0; j < n; j++) begin
      exp_i.push_back((f + j) % int'(NREGS));
      exp_d.push_back(rf[(f + j) % int'(NREGS)]);
    end

    start = 1'b1;
    first = AW'(f);
    last  = AW'(l);
    @(posedge clk);
    #1;
    start = 1'b0;
    first = AW'($urandom);
    last  = AW'($urandom);

    for (int c = 0; c < 4 * n + 20; c++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (noise) start = ($urandom_range(0, 3) == 0);
      #3;
      if (c == 0) begin
        check("read_no_valid", out_valid, 0);
        check("read_addr", rd_addr, DW'(f));
      end
      check("done_valid_excl", done & out_valid, 0);
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_data",  out_data,  pd);
        check("stall_index", out_index, pi);
        check("stall_last",  out_last,  pl);
      end
      if (out_valid) begin
        if (k >= n) begin
          check("extra_word", k, n - 1);
        end else begin
          check("word_index", out_index, exp_i[k]);
          check("word_data",  out_data,  exp_d[k]);
          check("word_last",  out_last,  (k == n - 1));
        end
        if (int'(out_index) == rst_idx) begin
          reset_n = 1'b0;
          #1;
          check_all_zero("midrst");
          @(posedge clk);
          #3;
          reset_n = 1'b1;
          start   = 1'b0;
          @(posedge clk);
          #1;
          check("midrst_idle_busy", busy, 0);
          check("midrst_idle_done", done, 0);
          return;
        end
        if (int'(out_index) == abort_idx) begin
          abort     = 1'b1;
          out_ready = 1'b0;
          @(posedge clk);
          #1;
          abort = 1'b0;
          start = 1'b0;
          check("abort_valid", out_valid, 0);
          check("abort_busy",  busy,      0);
          check("abort_done",  done,      0);
          repeat (2) begin
            @(posedge clk);
            #1;
            check("abort_no_done", done, 0);
          end
          return;
        end
        stalled = !out_ready;
        pd      = out_data;
        pi      = out_index;
        pl      = out_last;
        if (out_ready) k++;
      end else begin
        stalled = 0;
      end
      if (done) begin
        check("word_count", k, n);
        if (!rnd) check("done_cycle", c, 2 * n);
        fin = 1;
      end
      @(posedge clk);
      #1;
      if (fin) begin
        start = 1'b0;
        check("busy_after_done", busy, 0);
        check("done_one_cycle",  done, 0);
        break;
      end
    end
    start = 1'b0;
    if (!fin) check("dump_timeout", 0, 1);
  endtask

  initial begin
    for (int i = 0; i < int'(NREGS); i++) rf[i] = 32'h1000 + i;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Start with abort in the same cycle must not launch a dump.
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_ignored", busy, 0);

    dump(0, 31, 0, -1, -1, 0);
    dump(30, 1, 0, -1, -1, 0);
    rf[5] = 32'hDEAD_BEEF;
    dump(5, 5, 0, -1, -1, 0);
    dump(0, 7, 1, -1, -1, 0);
    dump(0, 10, 1, 3, -1, 0);
    dump(4, 4, 0, -1, -1, 0);
    dump(0, 10, 1, -1, 7, 0);

    repeat (6) begin
      for (int i = 0; i < int'(NREGS); i++) rf[i] = $urandom;
      dump(int'($urandom_range(0, NREGS - 1)), int'($urandom_range(0, NREGS - 1)), 1, -1, -1, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
